// File: rtl/square_motion_ctrl.sv
// Frame-synchronous position controller for a bouncing square: updates
// position during vertical blanking and emits a registered per-pixel draw flag.
module square_motion_ctrl #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int Q_SIZE = 32,
  parameter int SPDW   = 4,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             pause,
  input  logic [SPDW-1:0]  speed,
  output logic [CORDW-1:0] qx,
  output logic [CORDW-1:0] qy,
  output logic             q_draw,
  output logic             frame_tick,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;

  localparam logic [CORDW:0] X_MAX = (CORDW+1)'(H_RES - Q_SIZE);
  localparam logic [CORDW:0] Y_MAX = (CORDW+1)'(V_RES - Q_SIZE);
  localparam logic [CORDW:0] Q_W   = (CORDW+1)'(Q_SIZE);

  state_t          state, state_n;
  logic [SPDW-1:0] spd_r;
  logic            dir_x, dir_y;   // 1 = right / down
  logic            frame_start;
  logic [CORDW:0]  qx_w, qy_w, sx_w, sy_w, spd_w;
  logic [CORDW:0]  sum_x, sum_y;
  logic [CORDW-1:0] qx_n, qy_n;
  logic            dir_x_n, dir_y_n;
  logic            draw_c;

  assign frame_start = (sy == CORDW'(V_RES)) && (sx == '0);
  assign qx_w  = {1'b0, qx};
  assign qy_w  = {1'b0, qy};
  assign sx_w  = {1'b0, sx};
  assign sy_w  = {1'b0, sy};
  assign spd_w = (CORDW+1)'(spd_r);
  assign sum_x = qx_w + spd_w;
  assign sum_y = qy_w + spd_w;

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    case (state)
      IDLE:    if (frame_start && !pause) state_n = MOVE_X;
      MOVE_X:  begin busy = 1'b1; state_n = MOVE_Y; end
      MOVE_Y:  begin busy = 1'b1; state_n = DONE;   end
      DONE:    begin busy = 1'b1; state_n = IDLE;   end
      default: state_n = IDLE;
    endcase
  end

  // Edge hits clamp to the limit and flip; an exact hit at zero speed still flips.
  always_comb begin
    qx_n    = qx;
    dir_x_n = dir_x;
    if (dir_x) begin
      if (sum_x >= X_MAX) begin
        qx_n    = X_MAX[CORDW-1:0];
        dir_x_n = 1'b0;
      end else begin
        qx_n = sum_x[CORDW-1:0];
      end
    end else if (qx_w <= spd_w) begin
      qx_n    = '0;
      dir_x_n = 1'b1;
    end else begin
      qx_n = qx - spd_w[CORDW-1:0];
    end
  end

  always_comb begin
    qy_n    = qy;
    dir_y_n = dir_y;
    if (dir_y) begin
      if (sum_y >= Y_MAX) begin
        qy_n    = Y_MAX[CORDW-1:0];
        dir_y_n = 1'b0;
      end else begin
        qy_n = sum_y[CORDW-1:0];
      end
    end else if (qy_w <= spd_w) begin
      qy_n    = '0;
      dir_y_n = 1'b1;
    end else begin
      qy_n = qy - spd_w[CORDW-1:0];
    end
  end

  assign draw_c = (sx_w >= qx_w) && (sx_w < qx_w + Q_W) &&
                  (sy_w >= qy_w) && (sy_w < qy_w + Q_W);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state      <= IDLE;
      qx         <= CORDW'(INIT_X);
      qy         <= CORDW'(INIT_Y);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      spd_r      <= '0;
      frame_tick <= 1'b0;
      q_draw     <= 1'b0;
    end else begin
      state      <= state_n;
      frame_tick <= frame_start;
      q_draw     <= draw_c;
      if (state == IDLE && frame_start) spd_r <= speed;
      if (state == MOVE_X) begin
        qx    <= qx_n;
        dir_x <= dir_x_n;
      end
      if (state == MOVE_Y) begin
        qy    <= qy_n;
        dir_y <= dir_y_n;
      end
    end
  end

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Randomized bench for square_motion_ctrl: a per-frame position/direction
// model drives expectations for a default instance and a corner-start instance.
module tb_square_motion_ctrl;

  logic       clk_pix = 1'b0;
  logic       rst;
  logic [9:0] sx, sy;
  logic       pause;
  logic [3:0] speed;
  logic [9:0] qx, qy, cqx, cqy;
  logic       q_draw, frame_tick, busy;
  logic       c_draw, c_tick, c_busy;

  int checks = 0;
  int errors = 0;

  int mx[2], my[2];
  bit mdx[2], mdy[2];
  int ix[2] = '{0, 606};
  int iy[2] = '{0, 446};

  always #5 clk_pix = ~clk_pix;

  square_motion_ctrl dut (
    .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy), .pause(pause), .speed(speed),
    .qx(qx), .qy(qy), .q_draw(q_draw), .frame_tick(frame_tick), .busy(busy)
  );

  square_motion_ctrl #(.INIT_X(606), .INIT_Y(446)) dut_c (
    .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy), .pause(pause), .speed(speed),
    .qx(cqx), .qy(cqy), .q_draw(c_draw), .frame_tick(c_tick), .busy(c_busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One axis, one frame: move by s toward dir, stop at [0, lim] and bounce.
  task automatic axis(input int p, input bit d, input int s, input int lim,
                      output int np, output bit nd);
    np = p; nd = d;
    if (d) begin
      if (p + s >= lim) begin np = lim; nd = 1'b0; end
      else np = p + s;
    end else begin
      if (p <= s) begin np = 0; nd = 1'b1; end
      else np = p - s;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = ix[k]; my[k] = iy[k]; mdx[k] = 1'b1; mdy[k] = 1'b1;
    end
  endtask

  task automatic model_frame(input int s);
    for (int k = 0; k < 2; k++) begin
      axis(mx[k], mdx[k], s, 608, mx[k], mdx[k]);
      axis(my[k], mdy[k], s, 448, my[k], mdy[k]);
    end
  endtask

  function automatic bit inside_sq(input int k, input int x, input int y);
    return x >= mx[k] && x < mx[k] + 32 && y >= my[k] && y < my[k] + 32;
  endfunction

  task automatic check_pos(input string tag);
    check({tag, ".qx"},  int'(qx),  mx[0]);
    check({tag, ".qy"},  int'(qy),  my[0]);
    check({tag, ".cqx"}, int'(cqx), mx[1]);
    check({tag, ".cqy"}, int'(cqy), my[1]);
  endtask

  task automatic do_reset();
    @(negedge clk_pix);
    rst = 1'b1; sx = 10'd100; sy = 10'd100; pause = 1'b0; speed = 4'd0;
    repeat (2) @(negedge clk_pix);
    model_reset();
    check_pos("reset");
    check("reset.q_draw", int'(q_draw), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.tick", int'(frame_tick), 0);
    check("reset.c_busy", int'(c_busy), 0);
    rst = 1'b0;
  endtask

  task automatic run_frame(input bit p, input int s);
    int ticks, bcnt, cbcnt;
    ticks = 0; bcnt = 0; cbcnt = 0;
    @(negedge clk_pix);
    sx = 10'd0; sy = 10'd480; pause = p; speed = 4'(s);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_pix);
      if (frame_tick) ticks++;
      if (busy) bcnt++;
      if (c_busy) cbcnt++;
      sx = 10'(i); pause = 1'($urandom); speed = 4'($urandom);
    end
    if (!p) model_frame(s);
    check("frame.tick_count", ticks, 1);
    check("frame.busy_cycles", bcnt, p ? 0 : 3);
    check("frame.c_busy_cycles", cbcnt, p ? 0 : 3);
    check_pos("frame");
  endtask

  task automatic probe(input int x, input int y);
    @(negedge clk_pix);
    sx = 10'(x); sy = 10'(y);
    @(negedge clk_pix);
    check("probe.q_draw", int'(q_draw), int'(inside_sq(0, x, y)));
    check("probe.c_draw", int'(c_draw), int'(inside_sq(1, x, y)));
  endtask

  task automatic reset_mid_update(input int s);
    int ex;
    bit ed;
    @(negedge clk_pix);
    sx = 10'd0; sy = 10'd480; pause = 1'b0; speed = 4'(s);
    @(negedge clk_pix);
    sx = 10'd1;
    @(negedge clk_pix);
    axis(mx[0], mdx[0], s, 608, ex, ed);
    check("midrst.qx_moved", int'(qx), ex);
    check("midrst.busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk_pix);
    model_reset();
    check_pos("midrst");
    check("midrst.busy", int'(busy), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk_pix);
    check("midrst.busy_idle", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; sx = '0; sy = '0; pause = 1'b0; speed = '0;
    model_reset();
    do_reset();
    probe(5, 5);
    check("draw_5_5_expected", int'(q_draw), 1);
    probe(32, 0);
    check("draw_32_0_expected", int'(q_draw), 0);

    run_frame(1'b0, 4);
    check("first.qx", int'(qx), 4);
    check("corner.cqx", int'(cqx), 608);
    check("corner.cqy", int'(cqy), 448);
    run_frame(1'b0, 4);
    check("corner2.cqx", int'(cqx), 604);
    check("corner2.cqy", int'(cqy), 444);

    do_reset();
    repeat (40) run_frame(1'b0, 15);
    check("prebounce.qx", int'(qx), 600);
    run_frame(1'b0, 15);
    check("bounce.qx", int'(qx), 608);
    run_frame(1'b0, 15);
    check("bounce2.qx", int'(qx), 593);

    run_frame(1'b1, 7);
    run_frame(1'b0, 7);

    reset_mid_update(5);
    run_frame(1'b0, 9);

    for (int n = 0; n < 60; n++) begin
      run_frame($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
      for (int j = 0; j < 3; j++) begin
        int k;
        k = j % 2;
        probe((mx[k] + int'($urandom_range(0, 40)) + 636) % 640,
              (my[k] + int'($urandom_range(0, 40)) + 476) % 480);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
